// File: rtl/pwm_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pwm_ctrl_pkg
// Description : Shared widths, defaults and state type for the PWM duty
//               sequencer and its over-current monitor.
// Revision    : 1.0 - initial release
// ============================================================================
package pwm_ctrl_pkg;

    localparam int DUTY_W     = 11;
    localparam int OVR_CNT_W  = 4;

    localparam logic [DUTY_W-1:0] STEP_DEF      = 11'd16;
    localparam logic [DUTY_W-1:0] DUTY_MAX_DEF  = 11'h7F0;
    localparam int                OVR_LIMIT_DEF = 3;

    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        RAMP  = 2'd1,
        FAULT = 2'd2
    } ctrl_state_t;

    function automatic logic [DUTY_W-1:0] duty_clamp(
        input logic [DUTY_W-1:0] value,
        input logic [DUTY_W-1:0] ceiling
    );
        return (value > ceiling) ? ceiling : value;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_duty_ctrl_ovr_monitor.sv
`default_nettype none
// ============================================================================
// Module      : ovr_monitor
// Description : Blank-qualified over-current sampling and a consecutive
//               PWM-period counter; pulses trip when the run hits OVR_LIMIT.
// Revision    : 1.0 - initial release
// ============================================================================
module ovr_monitor
    import pwm_ctrl_pkg::*;
#(
    parameter int OVR_LIMIT = OVR_LIMIT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic PWM_synch,
    input  logic OVR_I,
    input  logic OVR_I_blank_n,
    input  logic duty_nz,
    input  logic clr,
    output logic trip
);

    logic                 r_seen;
    logic [OVR_CNT_W-1:0] r_cnt;
    logic                 w_qual;
    logic                 w_hit;
    logic [OVR_CNT_W-1:0] w_cnt_inc;

    assign w_qual    = OVR_I & OVR_I_blank_n & duty_nz;
    // A qualified sample on the period-end cycle itself still counts for that period.
    assign w_hit     = r_seen | w_qual;
    assign w_cnt_inc = (r_cnt == {OVR_CNT_W{1'b1}}) ? r_cnt : r_cnt + 1'b1;
    assign trip      = PWM_synch & w_hit & ~clr & (w_cnt_inc == OVR_CNT_W'(OVR_LIMIT));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_seen <= 1'b0;
            r_cnt  <= '0;
        end else if (PWM_synch) begin
            r_seen <= 1'b0;
            r_cnt  <= w_hit ? w_cnt_inc : '0;
        end else if (w_qual) begin
            r_seen <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pwm_duty_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pwm_duty_ctrl
// Description : Slews the PWM duty toward an accepted target once per PWM
//               period and latches an over-current fault that forces duty 0.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_duty_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter logic [DUTY_W-1:0] STEP      = STEP_DEF,
    parameter logic [DUTY_W-1:0] DUTY_MAX  = DUTY_MAX_DEF,
    parameter int                OVR_LIMIT = OVR_LIMIT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DUTY_W-1:0] tgt_duty,
    input  logic              tgt_vld,
    output logic              tgt_rdy,
    input  logic              PWM_synch,
    input  logic              OVR_I_blank_n,
    input  logic              OVR_I,
    input  logic              clr_fault,
    output logic [DUTY_W-1:0] duty,
    output logic              at_target,
    output logic              fault
);

    ctrl_state_t       r_state;
    logic [DUTY_W-1:0] r_duty;
    logic [DUTY_W-1:0] r_target;
    logic              r_fault;

    logic [DUTY_W-1:0] w_tgt_clamped;
    logic              w_accept;
    logic              w_up;
    logic [DUTY_W:0]   w_diff;
    logic              w_step_done;
    logic [DUTY_W-1:0] w_duty_step;
    logic              w_do_step;
    logic [DUTY_W-1:0] w_duty_nxt;
    logic              w_trip;

    assign w_tgt_clamped = duty_clamp(tgt_duty, DUTY_MAX);
    assign w_accept      = tgt_vld & tgt_rdy;

    assign w_up        = r_target > r_duty;
    assign w_diff      = w_up ? ({1'b0, r_target} - {1'b0, r_duty})
                              : ({1'b0, r_duty} - {1'b0, r_target});
    assign w_step_done = w_diff <= {1'b0, STEP};
    assign w_duty_step = w_step_done ? r_target
                       : (w_up ? r_duty + STEP : r_duty - STEP);
    assign w_do_step   = (r_state == RAMP) & PWM_synch;
    assign w_duty_nxt  = w_do_step ? w_duty_step : r_duty;

    ovr_monitor #(
        .OVR_LIMIT     (OVR_LIMIT)
    ) u_ovr_monitor (
        .clk           (clk),
        .rst           (rst),
        .PWM_synch     (PWM_synch),
        .OVR_I         (OVR_I),
        .OVR_I_blank_n (OVR_I_blank_n),
        .duty_nz       ((r_duty != '0) && (r_state != FAULT)),
        .clr           ((r_state == FAULT) && clr_fault),
        .trip          (w_trip)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= HOLD;
            r_duty   <= '0;
            r_target <= '0;
            r_fault  <= 1'b0;
        end else begin
            case (r_state)
                FAULT: begin
                    if (clr_fault) begin
                        r_state  <= HOLD;
                        r_fault  <= 1'b0;
                        r_target <= '0;
                    end
                end
                default: begin
                    if (w_trip) begin
                        r_state <= FAULT;
                        r_duty  <= '0;
                        r_fault <= 1'b1;
                    end else begin
                        r_duty <= w_duty_nxt;
                        if (w_do_step && w_step_done) begin
                            r_state <= HOLD;
                        end
                        // Compare against the post-step duty so a same-cycle step cannot strand HOLD off-target.
                        if (w_accept) begin
                            r_target <= w_tgt_clamped;
                            r_state  <= (w_tgt_clamped != w_duty_nxt) ? RAMP : HOLD;
                        end
                    end
                end
            endcase
        end
    end

    assign tgt_rdy   = (r_state != FAULT);
    assign at_target = (r_duty == r_target) && (r_state != FAULT);
    assign duty      = r_duty;
    assign fault     = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_pwm_duty_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_duty_ctrl
// Description : Directed plus randomized bench for pwm_duty_ctrl against an
//               integer behavioural model of the duty/fault rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_duty_ctrl;

    localparam int STEP  = 16;
    localparam int DMAX  = 'h7F0;
    localparam int LIMIT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] tgt_duty;
    logic        tgt_vld;
    logic        tgt_rdy;
    logic        PWM_synch;
    logic        OVR_I_blank_n;
    logic        OVR_I;
    logic        clr_fault;
    logic [10:0] duty;
    logic        at_target;
    logic        fault;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: ramping is implied whenever duty differs from target.
    int m_duty   = 0;
    int m_target = 0;
    int m_cnt    = 0;
    bit m_seen   = 0;
    bit m_fault  = 0;

    always #5 clk = ~clk;

    pwm_duty_ctrl #(
        .STEP          (11'd16),
        .DUTY_MAX      (11'h7F0),
        .OVR_LIMIT     (LIMIT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .tgt_duty      (tgt_duty),
        .tgt_vld       (tgt_vld),
        .tgt_rdy       (tgt_rdy),
        .PWM_synch     (PWM_synch),
        .OVR_I_blank_n (OVR_I_blank_n),
        .OVR_I         (OVR_I),
        .clr_fault     (clr_fault),
        .duty          (duty),
        .at_target     (at_target),
        .fault         (fault)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit v, input int td, input bit s,
                              input bit bn, input bit o, input bit c);
        bit q;
        bit hit;
        bit trip;
        int nd;
        int d;
        if (r) begin
            m_duty = 0; m_target = 0; m_cnt = 0; m_seen = 0; m_fault = 0;
        end else if (m_fault) begin
            if (c) begin
                m_fault = 0; m_target = 0; m_cnt = 0; m_seen = 0;
            end else if (s) begin
                m_cnt = 0; m_seen = 0;
            end
        end else begin
            q    = o && bn && (m_duty != 0);
            trip = 0;
            if (s) begin
                hit    = m_seen || q;
                m_cnt  = hit ? ((m_cnt < 15) ? m_cnt + 1 : 15) : 0;
                trip   = hit && (m_cnt == LIMIT);
                m_seen = 0;
            end else if (q) begin
                m_seen = 1;
            end
            if (trip) begin
                m_fault = 1;
                m_duty  = 0;
            end else begin
                nd = m_duty;
                if (s && (m_duty != m_target)) begin
                    d  = m_target - m_duty;
                    nd = (d <= STEP && d >= -STEP) ? m_target
                       : m_duty + ((d > 0) ? STEP : -STEP);
                end
                if (v) m_target = (td > DMAX) ? DMAX : td;
                m_duty = nd;
            end
        end
    endtask

    task automatic cycle(input bit r, input bit v, input int td, input bit s,
                         input bit bn, input bit o, input bit c);
        @(negedge clk);
        rst           = r;
        tgt_vld       = v;
        tgt_duty      = td[10:0];
        PWM_synch     = s;
        OVR_I_blank_n = bn;
        OVR_I         = o;
        clr_fault     = c;
        model_step(r, v, td, s, bn, o, c);
        @(posedge clk);
        #1;
        check_val("duty",      32'(duty),      32'(m_duty));
        check_val("fault",     32'(fault),     32'(m_fault));
        check_val("tgt_rdy",   32'(tgt_rdy),   32'(!m_fault));
        check_val("at_target", 32'(at_target), 32'(!m_fault && (m_duty == m_target)));
    endtask

    // Three quiet cycles then the period-end pulse; an optional request rides on the pulse cycle.
    task automatic period(input bit o, input bit bn, input bit v, input int td);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, bn, o, 0);
        cycle(0, v, td, 1, bn, o, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bit ovr_on;
        rst = 1'b1; tgt_vld = 1'b0; tgt_duty = '0; PWM_synch = 1'b0;
        OVR_I_blank_n = 1'b1; OVR_I = 1'b0; clr_fault = 1'b0;

        cycle(1, 0, 0, 0, 1, 0, 0);
        cycle(1, 0, 0, 0, 1, 0, 0);
        check_val("rst_duty", 32'(duty), 0);
        check_val("rst_rdy",  32'(tgt_rdy), 1);
        check_val("rst_at",   32'(at_target), 1);

        cycle(0, 1, 'h040, 0, 1, 0, 0);
        for (int k = 0; k < 4; k++) begin
            period(0, 1, 0, 0);
            check_val("ramp_up_duty", 32'(duty), 32'(16 * (k + 1)));
            check_val("ramp_up_at",   32'(at_target), 32'(k == 3));
        end

        cycle(0, 1, 'h045, 0, 1, 0, 0);
        period(0, 1, 0, 0);
        check_val("small_step", 32'(duty), 'h045);

        cycle(0, 1, 'h7FF, 0, 1, 0, 0);
        for (int i = 0; i < 200 && !at_target; i++) period(0, 1, 0, 0);
        check_val("clamp_duty", 32'(duty), 'h7F0);
        check_val("clamp_at",   32'(at_target), 1);

        cycle(1, 0, 0, 0, 1, 0, 0);
        cycle(0, 1, 'h200, 0, 1, 0, 0);
        for (int i = 0; i < 16; i++) period(0, 1, 0, 0);
        check_val("mid_ramp", 32'(duty), 'h100);
        cycle(0, 1, 'h0E8, 0, 1, 0, 0);
        period(0, 1, 0, 0);
        check_val("retarget_1", 32'(duty), 'h0F0);
        period(0, 1, 0, 0);
        check_val("retarget_2", 32'(duty), 'h0E8);
        check_val("retarget_at", 32'(at_target), 1);

        for (int i = 0; i < 5; i++) period(1, 0, 0, 0);
        check_val("blanked_ovr", 32'(fault), 0);
        period(1, 1, 0, 0);
        period(1, 1, 0, 0);
        period(0, 1, 0, 0);
        period(1, 1, 0, 0);
        period(1, 1, 0, 0);
        check_val("broken_run", 32'(fault), 0);

        period(0, 1, 0, 0);
        cycle(0, 1, 'h300, 0, 1, 0, 0);
        period(1, 1, 0, 0);
        period(1, 1, 0, 0);
        period(1, 1, 1, 'h123);
        check_val("trip_fault", 32'(fault), 1);
        check_val("trip_duty",  32'(duty), 0);
        check_val("trip_rdy",   32'(tgt_rdy), 0);
        cycle(0, 0, 0, 0, 1, 0, 1);
        check_val("clr_at",  32'(at_target), 1);
        check_val("clr_rdy", 32'(tgt_rdy), 1);

        cycle(0, 1, 'h400, 0, 1, 0, 0);
        for (int i = 0; i < 32; i++) period(0, 1, 0, 0);
        check_val("pre_rst_duty", 32'(duty), 'h200);
        cycle(1, 0, 0, 0, 1, 0, 0);
        check_val("rst_ramp_duty", 32'(duty), 0);
        cycle(0, 1, 'h100, 0, 1, 0, 0);
        period(0, 1, 0, 0);
        for (int i = 0; i < 3; i++) period(1, 1, 0, 0);
        check_val("fault_again", 32'(fault), 1);
        cycle(1, 0, 0, 0, 1, 0, 0);
        check_val("rst_fault", 32'(fault), 0);
        check_val("rst_fault_at", 32'(at_target), 1);

        ovr_on = 0;
        for (int i = 0; i < 4000; i++) begin
            bit o;
            int td;
            if ($urandom_range(0, 40) == 0) ovr_on = !ovr_on;
            o  = ovr_on ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 30) == 0);
            td = (($urandom_range(0, 3) == 0) ? m_duty + int'($urandom_range(0, 40)) - 20
                                               : int'($urandom_range(0, 2047))) & 'h7FF;
            cycle($urandom_range(0, 799) == 0, $urandom_range(0, 9) == 0, td,
                  $urandom_range(0, 5) == 0, $urandom_range(0, 7) != 0, o,
                  $urandom_range(0, 19) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
